hazard_controller: RTL

- Central pipeline sequencer for the 5-stage RV32 core.
- Generates stall, flush and clear controls for the F/D, D/E and E/M pipeline registers. Its flush_e output drives the clear input of the D/E control and data registers.
- Resolves load-use hazards, control redirects (taken branch or jump), and multi-cycle mul/div occupancy of the E stage.
- Produces the E-stage operand forwarding selects.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_controller_forward_unit.sv | 21 ++
 rtl/hazard_controller.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W    = 5;
   localparam int unsigned MD_CNT_W = 4;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Combinational E-stage operand forwarding select; M has priority over W.
module forward_unit
   import hazard_pkg::*;
(
   input  logic [REG_W-1:0] rs_e,
   input  logic [REG_W-1:0] rd_m,
   input  logic [REG_W-1:0] rd_w,
   input  logic             reg_write_m,
   input  logic             reg_write_w,
   output logic [1:0]       fwd_sel
);

   always_comb begin
      fwd_sel = FWD_RF;
      if (reg_write_m && (rd_m == rs_e) && (rs_e != '0))
         fwd_sel = FWD_M;
      else if (reg_write_w && (rd_w == rs_e) && (rs_e != '0))
         fwd_sel = FWD_W;
   end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: stall/flush control, mul/div E occupancy and forwarding.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
   import hazard_pkg::*;
#(
   parameter int unsigned MD_CYCLES = 4,
   parameter int unsigned PERF_W    = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [4:0]        rs1_d,
   input  logic [4:0]        rs2_d,
   input  logic [4:0]        rs1_e,
   input  logic [4:0]        rs2_e,
   input  logic [4:0]        rd_e,
   input  logic [4:0]        rd_m,
   input  logic [4:0]        rd_w,
   input  logic              reg_write_e,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic [1:0]        result_src_e,
   input  logic              pc_src_e,
   input  logic              md_req_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              md_last,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic [PERF_W-1:0] perf_stall_cnt,
   output logic [PERF_W-1:0] perf_flush_cnt
);

   hz_state_t             state, state_nxt;
   logic [MD_CNT_W-1:0]   md_cnt, md_cnt_nxt;
   logic [1:0]            fwd_a, fwd_b;
   logic                  lu;
   logic                  unused_inputs;

   // Load-use hazard does not depend on the E write enable: a load always writes.
   assign unused_inputs = reg_write_e;

   forward_unit u_fwd_a (
      .rs_e        (rs1_e),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_a)
   );

   forward_unit u_fwd_b (
      .rs_e        (rs2_e),
      .rd_m        (rd_m),
      .rd_w        (rd_w),
      .reg_write_m (reg_write_m),
      .reg_write_w (reg_write_w),
      .fwd_sel     (fwd_b)
   );

   assign forward_a_e = reset_n ? fwd_a : FWD_RF;
   assign forward_b_e = reset_n ? fwd_b : FWD_RF;

   assign lu = (result_src_e == RESULT_SRC_LOAD) && (rd_e != '0) &&
               ((rd_e == rs1_d) || (rd_e == rs2_d));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state  <= RUN;
         md_cnt <= '0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      md_cnt_nxt = md_cnt;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      stall_e    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      flush_m    = 1'b0;
      md_last    = 1'b0;
      if (!reset_n) begin
         flush_d    = 1'b1;
         flush_e    = 1'b1;
         flush_m    = 1'b1;
         state_nxt  = RUN;
         md_cnt_nxt = '0;
      end else begin
         case (state)
            RUN: begin
               if (md_req_e) begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  stall_e    = 1'b1;
                  flush_m    = 1'b1;
                  state_nxt  = MD_BUSY;
                  md_cnt_nxt = MD_CNT_W'(MD_CYCLES - 2);
               end else if (pc_src_e) begin
                  flush_d = 1'b1;
                  flush_e = 1'b1;
               end else if (lu) begin
                  stall_f = 1'b1;
                  stall_d = 1'b1;
                  flush_e = 1'b1;
               end
            end
            MD_BUSY: begin
               if (md_cnt != '0) begin
                  stall_f    = 1'b1;
                  stall_d    = 1'b1;
                  stall_e    = 1'b1;
                  flush_m    = 1'b1;
                  md_cnt_nxt = md_cnt - MD_CNT_W'(1);
               end else begin
                  md_last   = 1'b1;
                  state_nxt = RUN;
               end
            end
            default: state_nxt = RUN;
         endcase
      end
   end

`ifdef HAZARD_PERF_EN
   logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_f && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
         if ((flush_d || flush_e) && (flush_cnt_q != '1))
            flush_cnt_q <= flush_cnt_q + PERF_W'(1);
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
`endif

endmodule
